match_controller: RTL

MATCH_CONTROLLER -- requirements
Module: match_controller

---
 rtl/pong_pkg.sv | 19 +
 rtl/match_controller.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pong_pkg.sv
// Shared encodings and defaults for the pong game blocks
// (match controller, ball, render, seven_seg).
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  localparam int DEF_WIN_SCORE      = 9;
  localparam int DEF_SERVE_DELAY_MS = 1000;

endpackage

// File: rtl/match_controller.sv
// Pong match sequencing: start/serve handling, serve countdown,
// scoring and winner detection. All outputs are registered.
module match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE      = DEF_WIN_SCORE,
  parameter int SERVE_DELAY_MS = DEF_SERVE_DELAY_MS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1ms,
  input  logic       start,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [1:0] game_state,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       ball_run,
  output logic       serve_dir,
  output logic [1:0] winner
);

  localparam logic [3:0]  WIN4     = 4'(WIN_SCORE);
  localparam logic [11:0] CNT_LOAD = 12'(SERVE_DELAY_MS - 1);

  game_state_e state_q, state_d;
  logic [3:0]  p1_q, p1_d, p2_q, p2_d;
  logic [1:0]  winner_q, winner_d;
  logic        dir_q, dir_d;
  logic [11:0] cnt_q, cnt_d;
  logic        start_q;
  logic        ball_run_q;
  logic        start_re;

  assign start_re = start & ~start_q;

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_re) begin
          p1_d     = 4'd0;
          p2_d     = 4'd0;
          winner_d = WIN_NONE;
          dir_d    = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (start_re) begin
          state_d = ST_PLAY;
        end else if (clk_1ms) begin
          if (cnt_q == 12'd0) state_d = ST_PLAY;
          else                cnt_d   = cnt_q - 12'd1;
        end
      end
      ST_PLAY: begin
        // Simultaneous points are a disputed rally: nothing counts, re-serve.
        if (p1_point && p2_point) begin
          cnt_d   = CNT_LOAD;
          state_d = ST_SERVE;
        end else if (p1_point && p1_q < WIN4) begin
          p1_d  = p1_q + 4'd1;
          dir_d = 1'b1;
          if (p1_q + 4'd1 == WIN4) begin
            winner_d = WIN_P1;
            state_d  = ST_OVER;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_SERVE;
          end
        end else if (p2_point && p2_q < WIN4) begin
          p2_d  = p2_q + 4'd1;
          dir_d = 1'b0;
          if (p2_q + 4'd1 == WIN4) begin
            winner_d = WIN_P2;
            state_d  = ST_OVER;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_SERVE;
          end
        end
      end
      ST_OVER: begin
        if (start_re) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      p1_q       <= 4'd0;
      p2_q       <= 4'd0;
      winner_q   <= WIN_NONE;
      dir_q      <= 1'b1;
      cnt_q      <= 12'd0;
      start_q    <= 1'b1;  // a button held through reset must not fire
      ball_run_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      winner_q   <= winner_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      start_q    <= start;
      ball_run_q <= (state_d == ST_PLAY);
    end
  end

  assign game_state = state_q;
  assign p1_score   = p1_q;
  assign p2_score   = p2_q;
  assign winner     = winner_q;
  assign serve_dir  = dir_q;
  assign ball_run   = ball_run_q;

endmodule
